keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Keypad emulator: presses one hex key for HOLD_CYCLES clocks per request,
// then keeps it released for GAP_CYCLES clocks. While a key is held, its row
// line follows the synchronized column strobe from the scanner, mimicking a
// closed switch between that row and column.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned GAP_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       pressed,
  output logic       done,
  output logic       seen
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  krow_q, kcol_q;
  logic        ready_q, pressed_q, done_q, seen_q;
  logic [3:0]  col_s1_q, col_s2_q;
  logic [3:0]  row_q, row_d;
  logic [1:0]  dec_row, dec_col;
  logic        col_hit;

  // Key code to keypad position (row, column).
  always_comb begin
    dec_row = 2'd0;
    dec_col = 2'd0;
    case (key_in)
      4'h1: begin dec_row = 2'd0; dec_col = 2'd0; end
      4'h2: begin dec_row = 2'd0; dec_col = 2'd1; end
      4'h3: begin dec_row = 2'd0; dec_col = 2'd2; end
      4'hA: begin dec_row = 2'd0; dec_col = 2'd3; end
      4'h4: begin dec_row = 2'd1; dec_col = 2'd0; end
      4'h5: begin dec_row = 2'd1; dec_col = 2'd1; end
      4'h6: begin dec_row = 2'd1; dec_col = 2'd2; end
      4'hB: begin dec_row = 2'd1; dec_col = 2'd3; end
      4'h7: begin dec_row = 2'd2; dec_col = 2'd0; end
      4'h8: begin dec_row = 2'd2; dec_col = 2'd1; end
      4'h9: begin dec_row = 2'd2; dec_col = 2'd2; end
      4'hC: begin dec_row = 2'd2; dec_col = 2'd3; end
      4'h0: begin dec_row = 2'd3; dec_col = 2'd0; end
      4'hF: begin dec_row = 2'd3; dec_col = 2'd1; end
      4'hE: begin dec_row = 2'd3; dec_col = 2'd2; end
      4'hD: begin dec_row = 2'd3; dec_col = 2'd3; end
      default: begin dec_row = 2'd0; dec_col = 2'd0; end
    endcase
  end

  assign col_hit = ~col_s2_q[kcol_q];

  // Two-flop synchronizer for the asynchronous column lines (idle = 1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  // Request sequencer: IDLE -> PRESS (HOLD_CYCLES) -> GAP (GAP_CYCLES) -> IDLE.
  // done is registered, so it is loaded one cycle early: on GAP entry when
  // the gap is a single cycle, otherwise when the counter reaches 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      krow_q    <= '0;
      kcol_q    <= '0;
      ready_q   <= 1'b1;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid && ready_q) begin
            krow_q    <= dec_row;
            kcol_q    <= dec_col;
            cnt_q     <= HOLD_LOAD;
            seen_q    <= 1'b0;
            pressed_q <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= PRESS;
          end
        end
        PRESS: begin
          if (col_hit) seen_q <= 1'b1;
          if (cnt_q == '0) begin
            pressed_q <= 1'b0;
            cnt_q     <= GAP_LOAD;
            done_q    <= (GAP_LOAD == '0);
            state_q   <= GAP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_q - 16'd1;
            done_q <= (cnt_q == 16'd1);
          end
        end
        default: begin
          ready_q   <= 1'b1;
          pressed_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Row of the held key follows its synchronized column; all others released.
  always_comb begin
    row_d = '1;
    if (state_q == PRESS && col_hit) row_d[krow_q] = 1'b0;
  end

  // Registered row outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) row_q <= '1;
    else        row_q <= row_d;
  end

  assign key_ready = ready_q;
  assign pressed   = pressed_q;
  assign done      = done_q;
  assign seen      = seen_q;
  assign row       = row_q;

endmodule
